fetch_stage: RTL

Instruction-fetch (IF) stage of the five-stage pipelined ARM CPU. It holds the program counter and drives the byte address to the combinational 1024-byte instruction ROM. It registers the returned 32-bit word, with its PC, into the IF/ID pipeline register for decode. It applies branch redirects, hazard stalls and flushes, and stops fetching cleanly at the end of instruction memory.

---
 rtl/fetch_stage.sv | 70 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ROM address drive and the IF/ID register.
// Handles branch redirect, hazard stall and halt at the end of memory.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err
);

  logic [63:0] r_pc;
  logic [63:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic        r_id_valid;
  logic        r_misalign;

  logic [64:0] w_pc_last;
  logic        w_in_range;
  logic [63:0] w_br_pc;

  // 65-bit compare so a PC near 2^64 cannot wrap back into range
  assign w_pc_last  = {1'b0, r_pc} + 65'd3;
  assign w_in_range = w_pc_last < 65'(IMEM_SIZE);
  assign w_br_pc    = {br_target[63:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_id_pc    <= 64'h0;
      r_id_instr <= 32'h0;
      r_id_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else if (br_taken) begin
      r_pc       <= w_br_pc;
      r_id_pc    <= 64'h0;
      r_id_instr <= 32'h0;
      r_id_valid <= 1'b0;
      if (br_target[1:0] != 2'b00) r_misalign <= 1'b1;
    end else if (stall) begin
      r_pc       <= r_pc;
    end else if (!w_in_range) begin
      r_id_pc    <= 64'h0;
      r_id_instr <= 32'h0;
      r_id_valid <= 1'b0;
    end else begin
      r_pc       <= r_pc + 64'd4;
      r_id_pc    <= r_pc;
      r_id_instr <= imem_instr;
      r_id_valid <= 1'b1;
    end
  end

  assign imem_addr    = r_pc;
  assign if_id_pc     = r_id_pc;
  assign if_id_instr  = r_id_instr;
  assign if_id_valid  = r_id_valid;
  assign halted       = ~w_in_range;
  assign misalign_err = r_misalign;

endmodule
